// File: rtl/gray_counter_ud.sv
// Parametrised up/down Gray-code counter with synchronous load, boundary flags and a wrap pulse.
// The binary count and its Gray image are registered on the same edge so they never disagree.
module gray_counter_ud #(
    parameter int WIDTH    = 3,
    parameter int SATURATE = 0,
    parameter int STICKY   = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadGray,
    input  logic             FlagClr,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Count,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] load_bin;
    logic             ovf_event, unf_event;

    // Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it.
    assign load_bin[WIDTH-1] = LoadGray[WIDTH-1];
    generate
        for (genvar gi = WIDTH - 2; gi >= 0; gi--) begin : g_decode
            assign load_bin[gi] = load_bin[gi+1] ^ LoadGray[gi];
        end
    endgenerate

    always_comb begin
        count_d   = count_q;
        ovf_event = 1'b0;
        unf_event = 1'b0;
        if (Load) begin
            count_d = load_bin;
        end else if (En) begin
            if (Up) begin
                if (count_q == MAX_COUNT) begin
                    ovf_event = 1'b1;
                    count_d   = (SATURATE != 0) ? MAX_COUNT : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    unf_event = 1'b1;
                    count_d   = (SATURATE != 0) ? '0 : MAX_COUNT;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end

        gray_d = count_d ^ (count_d >> 1);
        wrap_d = ovf_event | unf_event;

        // An event in the same cycle as FlagClr keeps its flag set.
        if (STICKY != 0) begin
            overflow_d  = ovf_event | (overflow_q  & ~FlagClr);
            underflow_d = unf_event | (underflow_q & ~FlagClr);
        end else begin
            overflow_d  = ovf_event;
            underflow_d = unf_event;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q     <= '0;
            gray_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            count_q     <= count_d;
            gray_q      <= gray_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            wrap_q      <= wrap_d;
        end
    end

    assign Output    = gray_q;
    assign Count     = count_q;
    assign Overflow  = overflow_q;
    assign Underflow = underflow_q;
    assign Wrap      = wrap_q;

endmodule

// File: tb/tb_gray_counter_ud.sv
// Three counter configurations driven by shared stimulus and checked against an integer model.
// Instance 0: W=3 wrap sticky; instance 1: W=3 saturate sticky; instance 2: W=5 wrap pulse flags.
module tb_gray_counter_ud;

    logic        Clk = 1'b0;
    logic        Reset, En, Up, Load, FlagClr;
    logic [15:0] lg;

    logic [2:0] out0, cnt0, out1, cnt1;
    logic [4:0] out2, cnt2;
    logic       ov0, un0, wr0, ov1, un1, wr1, ov2, un2, wr2;

    int total = 0;
    int bad   = 0;

    int p_w[3]   = '{3, 3, 5};
    int p_sat[3] = '{0, 1, 0};
    int p_stk[3] = '{1, 1, 0};
    int m_c[3], m_ov[3], m_un[3], m_wr[3];

    always #5 Clk = ~Clk;

    gray_counter_ud #(.WIDTH(3), .SATURATE(0), .STICKY(1)) u0 (
        .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .LoadGray(lg[2:0]),
        .FlagClr(FlagClr), .Output(out0), .Count(cnt0), .Overflow(ov0), .Underflow(un0), .Wrap(wr0));
    gray_counter_ud #(.WIDTH(3), .SATURATE(1), .STICKY(1)) u1 (
        .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .LoadGray(lg[2:0]),
        .FlagClr(FlagClr), .Output(out1), .Count(cnt1), .Overflow(ov1), .Underflow(un1), .Wrap(wr1));
    gray_counter_ud #(.WIDTH(5), .SATURATE(0), .STICKY(0)) u2 (
        .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .LoadGray(lg[4:0]),
        .FlagClr(FlagClr), .Output(out2), .Count(cnt2), .Overflow(ov2), .Underflow(un2), .Wrap(wr2));

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Gray decode as repeated XOR of the right-shifted code.
    function automatic int gray_to_int(input int g, input int w);
        int b = g;
        for (int s = 1; s < w; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic int int_to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_step(input int k);
        int top = (1 << p_w[k]) - 1;
        int oe = 0, ue = 0;
        if (Reset) begin
            m_c[k] = 0; m_ov[k] = 0; m_un[k] = 0; m_wr[k] = 0;
            return;
        end
        if (Load) begin
            m_c[k] = gray_to_int(int'(lg) & top, p_w[k]);
        end else if (En) begin
            if (Up) begin
                if (m_c[k] == top) begin oe = 1; m_c[k] = p_sat[k] ? top : 0; end
                else m_c[k] = m_c[k] + 1;
            end else begin
                if (m_c[k] == 0) begin ue = 1; m_c[k] = p_sat[k] ? 0 : top; end
                else m_c[k] = m_c[k] - 1;
            end
        end
        m_wr[k] = oe | ue;
        if (p_stk[k]) begin
            m_ov[k] = oe | (m_ov[k] & int'(!FlagClr));
            m_un[k] = ue | (m_un[k] & int'(!FlagClr));
        end else begin
            m_ov[k] = oe;
            m_un[k] = ue;
        end
    endtask

    task automatic chk_inst(input int k, input int o, input int c, input int ov, input int un, input int wr);
        chk($sformatf("u%0d.Count", k),     c,  m_c[k]);
        chk($sformatf("u%0d.Output", k),    o,  int_to_gray(m_c[k]));
        chk($sformatf("u%0d.Overflow", k),  ov, m_ov[k]);
        chk($sformatf("u%0d.Underflow", k), un, m_un[k]);
        chk($sformatf("u%0d.Wrap", k),      wr, m_wr[k]);
    endtask

    // One clock edge: advance the models, then compare every instance just after the edge.
    task automatic tick();
        @(posedge Clk);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        chk_inst(0, int'(out0), int'(cnt0), int'(ov0), int'(un0), int'(wr0));
        chk_inst(1, int'(out1), int'(cnt1), int'(ov1), int'(un1), int'(wr1));
        chk_inst(2, int'(out2), int'(cnt2), int'(ov2), int'(un2), int'(wr2));
        $display("t=%0t R=%0b L=%0b E=%0b U=%0b C=%0b lg=%h | u0 c=%0d g=%0d w=%0b | u1 c=%0d | u2 c=%0d",
                 $time, Reset, Load, En, Up, FlagClr, lg, cnt0, out0, wr0, cnt1, cnt2);
    endtask

    task automatic drive(input logic r, input logic l, input logic e, input logic u,
                         input logic fc, input logic [15:0] g);
        Reset = r; Load = l; En = e; Up = u; FlagClr = fc; lg = g;
    endtask

    int up_gray[9] = '{1, 3, 2, 6, 7, 5, 4, 0, 1};
    logic [2:0] prev_gray;

    initial begin
        for (int k = 0; k < 3; k++) begin m_c[k] = 0; m_ov[k] = 0; m_un[k] = 0; m_wr[k] = 0; end
        drive(1, 0, 0, 0, 0, 16'h0);
        tick();
        tick();
        chk("reset.out0", int'(out0), 0);
        chk("reset.ov0", int'(ov0), 0);

        // Continuous up-count through the wrap.
        drive(0, 0, 1, 1, 0, 16'h0);
        prev_gray = out0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("up.gray[%0d]", i), int'(out0), up_gray[i]);
            chk($sformatf("up.wrap[%0d]", i), int'(wr0), (i == 7) ? 1 : 0);
            chk($sformatf("up.ovf[%0d]", i), int'(ov0), (i >= 7) ? 1 : 0);
            chk($sformatf("up.onebit[%0d]", i), $countones(prev_gray ^ out0), 1);
            prev_gray = out0;
        end

        // Down-count from reset.
        drive(1, 0, 0, 0, 0, 16'h0);
        tick();
        drive(0, 0, 1, 0, 0, 16'h0);
        tick();
        chk("down.cnt", int'(cnt0), 7);
        chk("down.out", int'(out0), 4);
        chk("down.unf", int'(un0), 1);
        chk("down.wrap", int'(wr0), 1);
        tick();
        tick();
        chk("down2.cnt", int'(cnt0), 5);
        chk("down2.out", int'(out0), 7);

        // Load, then load with enable asserted.
        drive(0, 1, 0, 1, 0, 16'h0005);
        tick();
        chk("load.cnt", int'(cnt0), 6);
        chk("load.out", int'(out0), 5);
        drive(0, 1, 1, 1, 0, 16'h0002);
        tick();
        chk("load_en.cnt", int'(cnt0), 3);

        // Saturation on instance 1.
        drive(0, 1, 0, 1, 0, 16'h0004);
        tick();
        chk("sat.load", int'(cnt1), 7);
        drive(0, 0, 1, 1, 0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("sat.cnt[%0d]", i), int'(cnt1), 7);
            chk($sformatf("sat.out[%0d]", i), int'(out1), 4);
            chk($sformatf("sat.wrap[%0d]", i), int'(wr1), 1);
            chk($sformatf("sat.ovf[%0d]", i), int'(ov1), 1);
        end

        // Flag clear race: a new event wins over FlagClr, a quiet cycle clears.
        drive(0, 0, 1, 1, 1, 16'h0);
        tick();
        chk("race.set_wins", int'(ov1), 1);
        drive(0, 0, 0, 1, 1, 16'h0);
        tick();
        chk("race.cleared", int'(ov1), 0);

        // Reset overrides load and enable.
        drive(0, 1, 0, 0, 0, 16'h0007);
        tick();
        chk("rstmid.pre", int'(cnt0), 5);
        drive(1, 1, 1, 1, 1, 16'h0003);
        tick();
        chk("rstmid.cnt", int'(cnt0), 0);
        chk("rstmid.out", int'(out0), 0);
        chk("rstmid.wrap", int'(wr0), 0);

        // Random traffic against the models.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
                  1'($urandom),
                  ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
                  16'($urandom));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_counter_ud.md
Name: gray_counter_ud

Overview:
- Parametrised up/down Gray-code counter with a synchronous load.
- Binary count and Gray-coded output are always kept consistent.
- Sticky overflow/underflow flags plus a one-cycle wrap pulse.
- Optional saturating mode.
- Generalises the 3-bit up-only Gray counter for use as a pointer or position source elsewhere in the design, such as FIFO pointers and encoder positions.

Parameters:
- WIDTH, 3: counter width in bits. Legal range is 2..16.
- SATURATE, 0: 0 means the count wraps at the boundary. 1 means the count holds at the boundary.
- STICKY, 1: 1 means Overflow/Underflow hold until cleared. 0 means they are one-cycle pulses.

Ports:
- Clk, input, 1: rising-edge clock.
- Reset, input, 1: synchronous, active-high reset.
- En, input, 1: count enable.
- Up, input, 1: direction. 1 counts up, 0 counts down. Sampled only when En=1.
- Load, input, 1: synchronous load strobe.
- LoadGray, input, WIDTH: Gray-coded load value, decoded to binary internally.
- FlagClr, input, 1: clears Overflow and Underflow.
- Output, output, WIDTH: registered Gray code of Count.
- Count, output, WIDTH: registered binary count.
- Overflow, output, 1: an up-count was attempted at the all-ones count.
- Underflow, output, 1: a down-count was attempted at count 0.
- Wrap, output, 1: one-cycle pulse on any boundary event, whether the count wraps or saturates.

Behaviour:
- Clock and reset: reset Reset, synchronous, active-high; clock Clk. Every state change happens on the rising edge of Clk.
- Reset values: Count=0, Output=0, Overflow=0, Underflow=0, Wrap=0.
- Priority per cycle: Reset > Load > En > hold.
- Load:
  - Count <= gray2bin(LoadGray). Decode rule: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].
  - Output <= LoadGray.
  - Wrap <= 0. Flags are unchanged except by FlagClr.
  - En is ignored in the same cycle.
- Count up (En=1, Up=1, Load=0):
  - If Count != 2^WIDTH-1: Count <= Count+1.
  - Else, with SATURATE=0: Count <= 0.
  - Else, with SATURATE=1: Count holds at 2^WIDTH-1.
  - In either boundary case: Overflow <= 1 and Wrap <= 1.
- Count down (En=1, Up=0, Load=0):
  - If Count != 0: Count <= Count-1.
  - Else, with SATURATE=0: Count <= 2^WIDTH-1.
  - Else, with SATURATE=1: Count holds at 0.
  - In either boundary case: Underflow <= 1 and Wrap <= 1.
- Output encoding: Output <= next_bin ^ (next_bin >> 1), computed from the next binary value.
  - Output and Count update on the same edge, so latency is 1 cycle from the enabling edge.
  - Output never lags Count.
- Idle: with En=0 and Load=0, Count and Output hold and Wrap <= 0.
- Wrap timing: Wrap is high only in the cycle after a boundary event. Consecutive saturated boundary events keep Wrap high every cycle.
- Flags with STICKY=1:
  - A flag stays high until FlagClr=1 or Reset.
  - FlagClr in the same cycle as a new event of the same type: set wins, and the flag stays 1.
  - FlagClr clears only the flag type that has no event in that cycle.
- Flags with STICKY=0: each flag mirrors Wrap qualified by direction. FlagClr has no effect.
- Direction changes: Up may change on any cycle with no penalty or bubble.
- Reset mid-count: the next edge forces every register to its reset value, regardless of En, Load and FlagClr.
- Gray property: with SATURATE=0, successive Output values under continuous counting differ in exactly one bit, including across the wrap.
- Arithmetic: all arithmetic is unsigned modulo 2^WIDTH. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset then up-count, WIDTH=3, SATURATE=0, En=1, Up=1, 9 edges:
  - Output=1,3,2,6,7,5,4,0,1.
  - Wrap=1 only in the cycle where Output=0.
  - Overflow=1 from the 8th edge on.
  - Each step flips one bit.
- Down from reset, WIDTH=3, Up=0, 1 edge:
  - Count=7, Output=4, Underflow=1, Wrap=1.
  - Then 2 more edges give Count=5, Output=7.
- Load, then simultaneous load and count:
  - Load=1 with LoadGray=3'b101 gives Count=6, Output=5.
  - Load=1 with En=1 and LoadGray=3'b010 gives Count=3 and no increment.
- Saturate, SATURATE=1:
  - Load LoadGray=3'b100 (Count=7), then 3 up-edges.
  - Count stays 7 and Output stays 4.
  - Wrap=1 on all three cycles, Overflow=1.
- Flag clear race, STICKY=1, Overflow=1, Count=7:
  - FlagClr=1 with En=1, Up=1 gives Overflow=1, because set wins.
  - Next cycle, FlagClr=1 with En=0 gives Overflow=0.
- Reset mid-operation:
  - Count=5 with En=1, Load=1, Reset=1.
  - Next edge gives all outputs 0.
